// File: rtl/i2s_pkg.sv
// ---------------------------------------------------------------------------
// i2s_pkg
// Shared types and constants for the I2S TX sample path.
//   i2s_mux_state_e : slot scheduler state of the TX stream mux
//   I2S_DATA_WIDTH  : default sample word width of the TX channel
// ---------------------------------------------------------------------------
package i2s_pkg;

    localparam int I2S_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } i2s_mux_state_e;

endpackage : i2s_pkg

// File: rtl/i2s_tx_stream_mux_if.sv
// ---------------------------------------------------------------------------
// i2s_tx_stream_mux_if
// Sample-path bundle around the I2S TX stream mux. Signal suffixes are seen
// from the mux side, so the mux uses the master modport and the uDMA buffers
// / TX channel (or a testbench) use the slave modport.
//   l_data_i / l_valid_i / l_ready_o   left-stream valid/ready sample port
//   r_data_i / r_valid_i / r_ready_o   right-stream valid/ready sample port
//   fifo_data_o / fifo_data_valid_o    sample presented to the TX channel
//   fifo_data_ready_i                  TX channel consumes fifo_data_o
// ---------------------------------------------------------------------------
interface i2s_tx_stream_mux_if
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH = I2S_DATA_WIDTH
);

    logic [DATA_WIDTH-1:0] l_data_i;
    logic                  l_valid_i;
    logic                  l_ready_o;

    logic [DATA_WIDTH-1:0] r_data_i;
    logic                  r_valid_i;
    logic                  r_ready_o;

    logic [DATA_WIDTH-1:0] fifo_data_o;
    logic                  fifo_data_valid_o;
    logic                  fifo_data_ready_i;

    modport master (
        input  l_data_i, l_valid_i,
        input  r_data_i, r_valid_i,
        input  fifo_data_ready_i,
        output l_ready_o, r_ready_o,
        output fifo_data_o, fifo_data_valid_o
    );

    modport slave (
        output l_data_i, l_valid_i,
        output r_data_i, r_valid_i,
        output fifo_data_ready_i,
        input  l_ready_o, r_ready_o,
        input  fifo_data_o, fifo_data_valid_o
    );

endinterface : i2s_tx_stream_mux_if

// File: rtl/i2s_tx_stream_mux.sv
// ---------------------------------------------------------------------------
// i2s_tx_stream_mux
// Schedules the left and right uDMA sample streams onto the single sample
// port of the I2S TX channel in strict L,R,L,R slot order (L only in mono).
// A slot the TX channel consumes while no sample is staged is an underrun:
// the fill word goes out, the slot is skipped so L/R alignment holds, and a
// saturating counter records it. Runs entirely in the sck_i domain.
//
// Ports
//   sck_i           serial bit clock, the only clock
//   rstn_i          synchronous active-low reset
//   cfg_en_i        enables scheduling; low empties the output register
//   cfg_2ch_i       1: alternate L/R, 0: left stream only
//   cfg_clr_cnt_i   clears the underrun counter (wins over an increment)
//   bus             sample streams and TX channel port (master modport)
//   underrun_o      one-cycle pulse after an underrun slot
//   underrun_cnt_o  saturating underrun count
//   busy_o          scheduler is not idle
//
// Configuration macro
//   I2S_TX_MUX_HOLD_LAST_EN  when defined, the fill word is the last sample
//                            loaded for the current slot's channel instead
//                            of the FILL_WORD parameter.
// ---------------------------------------------------------------------------
module i2s_tx_stream_mux
    import i2s_pkg::*;
#(
    parameter int                    DATA_WIDTH = I2S_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] FILL_WORD  = '0,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  sck_i,
    input  logic                  rstn_i,
    input  logic                  cfg_en_i,
    input  logic                  cfg_2ch_i,
    input  logic                  cfg_clr_cnt_i,
    i2s_tx_stream_mux_if.master   bus,
    output logic                  underrun_o,
    output logic [CNT_WIDTH-1:0]  underrun_cnt_o,
    output logic                  busy_o
);

    i2s_mux_state_e        state_q, state_d;
    logic                  outValid_q, outValid_d;
    logic [DATA_WIDTH-1:0] outData_q, outData_d;
    logic                  underrunPulse_q;
    logic [CNT_WIDTH-1:0]  underrunCnt_q, underrunCnt_d;

    logic                  srcValid;
    logic [DATA_WIDTH-1:0] srcData;
    logic                  srcReady;
    logic                  load;
    logic                  consume;
    logic                  underrun;
    logic                  slotAdvance;
    logic [DATA_WIDTH-1:0] fillWord;

    // Select the stream owning the current slot and decide whether it may
    // hand over a word. A staged word only makes room when the channel
    // takes it this cycle; an empty register may only be filled when the
    // channel is not consuming, since a consume from empty is an underrun
    // and that slot is dropped rather than handshaken.
    always_comb begin
        srcValid = 1'b0;
        srcData  = '0;
        case (state_q)
            ST_LEFT: begin
                srcValid = bus.l_valid_i;
                srcData  = bus.l_data_i;
            end
            ST_RIGHT: begin
                srcValid = bus.r_valid_i;
                srcData  = bus.r_data_i;
            end
            default: begin
                srcValid = 1'b0;
                srcData  = '0;
            end
        endcase

        srcReady = cfg_en_i && (state_q != ST_IDLE) &&
                   (outValid_q ? bus.fifo_data_ready_i : !bus.fifo_data_ready_i);

        load        = srcReady && srcValid;
        consume     = bus.fifo_data_ready_i && outValid_q;
        underrun    = bus.fifo_data_ready_i && !outValid_q && (state_q != ST_IDLE);
        slotAdvance = load || underrun;
    end

    assign bus.l_ready_o = srcReady && (state_q == ST_LEFT);
    assign bus.r_ready_o = srcReady && (state_q == ST_RIGHT);

    // Slot scheduler next state. The channel mode is sampled only when a
    // slot advances, so a mode change lands on a slot boundary. Disabling
    // always parks in IDLE so a re-enable restarts on the left slot.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_en_i) state_d = ST_LEFT;
            end
            ST_LEFT: begin
                if (slotAdvance) state_d = cfg_2ch_i ? ST_RIGHT : ST_LEFT;
            end
            ST_RIGHT: begin
                if (slotAdvance) state_d = ST_LEFT;
            end
            default: state_d = ST_IDLE;
        endcase
        if (!cfg_en_i) state_d = ST_IDLE;
    end

    // Output register: a load may coincide with a consume, which gives one
    // word per cycle back-to-back. Disabling drops any staged word.
    always_comb begin
        outValid_d = outValid_q;
        outData_d  = outData_q;
        if (!cfg_en_i) begin
            outValid_d = 1'b0;
        end else if (load) begin
            outValid_d = 1'b1;
            outData_d  = srcData;
        end else if (consume) begin
            outValid_d = 1'b0;
        end
    end

    // Underrun counter saturates at all-ones; a clear request takes
    // priority over an increment in the same cycle.
    always_comb begin
        underrunCnt_d = underrunCnt_q;
        if (cfg_clr_cnt_i) begin
            underrunCnt_d = '0;
        end else if (underrun && !(&underrunCnt_q)) begin
            underrunCnt_d = underrunCnt_q + 1'b1;
        end
    end

    always_ff @(posedge sck_i) begin
        if (!rstn_i) begin
            state_q         <= ST_IDLE;
            outValid_q      <= 1'b0;
            outData_q       <= '0;
            underrunPulse_q <= 1'b0;
            underrunCnt_q   <= '0;
        end else begin
            state_q         <= state_d;
            outValid_q      <= outValid_d;
            outData_q       <= outData_d;
            underrunPulse_q <= underrun;
            underrunCnt_q   <= underrunCnt_d;
        end
    end

`ifdef I2S_TX_MUX_HOLD_LAST_EN
    logic [DATA_WIDTH-1:0] holdL_q;
    logic [DATA_WIDTH-1:0] holdR_q;

    // Remember the last sample loaded per channel so an underrun slot
    // repeats that channel's previous sample instead of emitting silence.
    always_ff @(posedge sck_i) begin
        if (!rstn_i) begin
            holdL_q <= '0;
            holdR_q <= '0;
        end else if (load) begin
            if (state_q == ST_LEFT)  holdL_q <= srcData;
            if (state_q == ST_RIGHT) holdR_q <= srcData;
        end
    end

    assign fillWord = (state_q == ST_RIGHT) ? holdR_q : holdL_q;
`else
    assign fillWord = FILL_WORD;
`endif

    assign bus.fifo_data_o       = outValid_q ? outData_q : fillWord;
    assign bus.fifo_data_valid_o = outValid_q;
    assign underrun_o            = underrunPulse_q;
    assign underrun_cnt_o        = underrunCnt_q;
    assign busy_o                = (state_q != ST_IDLE);

endmodule : i2s_tx_stream_mux
